shift_scheduler: RTL and testbench
==================================

Name: shift_scheduler

Overview:
- Shares one 8-bit barrel shifter between two requesters for the physics accelerator datapath.
- The shifter is an `Shifter_8_bit` instance with shifterMode = SHIFTER_MODE and a 3-bit amount, so each pass shifts at most 7.
- The block round-robin arbitrates the two requesters and accepts a 5-bit shift amount (0..31).
- It sequences the op as multiple shifter passes and returns the result over a valid/ready response port tagged with the requester id.

Parameters:
- SHIFTER_MODE, 0, passed to the shifter instance: 0 LSL, 1 ROL, 2 LSR, 3 ASR, 4 ROR.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an op.
- req0_ready  output  1  requester 0 op accepted this cycle.
- req0_data  input  8  requester 0 operand.
- req0_amount  input  5  requester 0 shift amount.
- req1_valid / req1_ready / req1_data / req1_amount  same widths and meaning for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes result.
- rsp_data  output  8  shifted result.
- rsp_id  output  1  requester that issued the op.
- busy  output  1  high in SHIFT or RESP.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state = IDLE.
  - Priority pointer = requester 0.
  - rsp_valid = 0, rsp_data = 0x00, rsp_id = 0, busy = 0.
  - req0_ready and req1_ready are forced 0 while rst_n is low.
- FSM states: IDLE, SHIFT, RESP.
- IDLE:
  - Grant is combinational. If only one valid is high, that requester is granted. If both are high, the priority-pointer requester is granted.
  - reqN_ready = (state == IDLE) and grant == N. Only one ready is ever high at a time.
  - Handshake (valid & ready) latches: work = data, id = N.
  - rem = amount for modes 0, 2, 3; rem = amount[2:0] for rotate modes 1 and 4.
  - Next state: SHIFT if rem != 0, else RESP.
- SHIFT:
  - step = min(rem, 7) drives the shifter amount input, with work as the shifter data input.
  - On each edge: work <= shifter result; rem <= rem - step.
  - When rem - step == 0, go to RESP.
  - Passes P = ceil(rem/7); maximum 5 (amount 31). Repeated passes compose exactly:
    - LSL/LSR with amount >= 8 yields 0x00.
    - ASR with amount >= 8 yields the sign fill.
- RESP:
  - rsp_valid = 1; rsp_data = work; rsp_id = id. All three are registered and held stable while rsp_ready is low.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, state <= IDLE, priority pointer <= ~id.
  - No new request is accepted before the response handshake completes.
- Latency: with the handshake in cycle C0, rsp_valid is first high in cycle C(P+1). Amount 0 gives rsp_valid in C1.
- Throughput: one op at a time. The earliest next accept is the cycle after the response handshake (IDLE cycle).
- Inputs sampled only at accept: req data and amount changes after accept do not affect the op in flight.
- Reset mid-op: asynchronous reset at any state discards the op immediately. rsp_valid drops, the pointer returns to 0, and no response is produced for the discarded op.
- No error conditions exist; all 5-bit amounts are legal.

Test Plan:
- SHIFTER_MODE=0, req0 data 0x81 amount 1 -> accept C0; rsp_valid in C2; rsp_data 0x02, rsp_id 0.
- SHIFTER_MODE=0, req1 data 0x01 amount 31 -> 5 SHIFT cycles; rsp_valid in C6; rsp_data 0x00, rsp_id 1. Also amount 0 data 0x5A -> rsp_valid in C1, rsp_data 0x5A.
- SHIFTER_MODE=3, data 0x80 amount 20 -> P=3, rsp_data 0xFF. Also data 0x40 amount 6 -> rsp_data 0x01.
- SHIFTER_MODE=4, data 0x01 amount 9 -> treated as 1, P=1, rsp_data 0x80 in C2. Also SHIFTER_MODE=1, data 0x81 amount 8 -> rem 0, rsp_data 0x81 in C1.
- Arbitration:
  - After reset, both valid held high -> order of rsp_id is 0, 1, 0, 1.
  - Only req1 valid -> req1 granted immediately despite the pointer at 0.
  - Both ready signals are never high together.
- Backpressure and reset:
  - rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable, and no reqN_ready asserted.
  - rst_n pulsed low during SHIFT of amount 31 -> outputs return to reset values immediately, and no response is produced after release.

Source files
------------

// File: rtl/shift_scheduler.sv
// ---------------------------------------------------------------------------
// shift_scheduler
//   Shares one 8-bit barrel shifter (max 7 per pass) between two requesters.
//   Each accepted op carries a 5-bit amount (0..31) and is executed as a
//   sequence of shifter passes. The result goes out on a registered
//   valid/ready response port tagged with the issuing requester id.
//
// Handshake rule (request and response ports alike): a transfer happens on
// a rising clk edge where valid and ready are both high. Request-side valid
// may be raised at any time. The response holds rsp_valid, rsp_data and
// rsp_id stable until it is taken.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req0_valid/ready/data/amount requester 0 op (data 8b, amount 5b)
//   req1_valid/ready/data/amount requester 1 op
//   rsp_valid/ready/data/id     result port (data 8b, id = requester)
//   busy                        high while an op is in SHIFT or RESP
//   dbg_state_o                 current FSM state (0 IDLE, 1 SHIFT, 2 RESP)
// ---------------------------------------------------------------------------

// Single-pass 8-bit shifter. shifterMode: 0 LSL, 1 ROL, 2 LSR, 3 ASR, 4 ROR.
module Shifter_8_bit #(
  parameter int shifterMode = 0
) (
  input  logic [7:0] data_i,
  input  logic [2:0] amount_i,
  output logic [7:0] result_o
);
  logic [3:0] inv_amount;

  // A shift by 8 moves everything out, so amount 0 rotates cleanly.
  assign inv_amount = 4'd8 - {1'b0, amount_i};

  always_comb begin
    case (shifterMode)
      0:       result_o = data_i << amount_i;
      1:       result_o = (data_i << amount_i) | (data_i >> inv_amount);
      2:       result_o = data_i >> amount_i;
      3:       result_o = $unsigned($signed(data_i) >>> amount_i);
      4:       result_o = (data_i >> amount_i) | (data_i << inv_amount);
      default: result_o = data_i;
    endcase
  end
endmodule

module shift_scheduler #(
  parameter int SHIFTER_MODE = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  input  logic [4:0] req0_amount,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  input  logic [4:0] req1_amount,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id,
  output logic       busy,
  output logic [1:0] dbg_state_o
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Rotations repeat every 8, so only amount[2:0] matters for them.
  localparam logic [4:0] AMOUNT_MASK =
    ((SHIFTER_MODE == 1) || (SHIFTER_MODE == 4)) ? 5'b00111 : 5'b11111;

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] work_q, work_d;
  logic [4:0] rem_q, rem_d;
  logic       id_q, id_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_id_q, rsp_id_d;

  logic       any_valid;
  logic       grant;
  logic [7:0] grant_data;
  logic [4:0] grant_amount;
  logic [4:0] accept_rem;
  logic [2:0] step;
  logic [4:0] rem_after;
  logic [7:0] shift_res;

  // Round-robin: the pointer only breaks ties, a lone requester always wins.
  assign any_valid    = req0_valid | req1_valid;
  assign grant        = (req0_valid && req1_valid) ? ptr_q : req1_valid;
  assign grant_data   = grant ? req1_data : req0_data;
  assign grant_amount = grant ? req1_amount : req0_amount;
  assign accept_rem   = grant_amount & AMOUNT_MASK;

  // rst_n gates the readies so nothing looks accepted while reset is held.
  assign req0_ready = rst_n && (state_q == IDLE) && any_valid && !grant;
  assign req1_ready = rst_n && (state_q == IDLE) && any_valid && grant;

  assign step      = (rem_q > 5'd7) ? 3'd7 : rem_q[2:0];
  assign rem_after = rem_q - {2'b00, step};

  Shifter_8_bit #(
    .shifterMode(SHIFTER_MODE)
  ) u_shifter (
    .data_i  (work_q),
    .amount_i(step),
    .result_o(shift_res)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    work_d      = work_q;
    rem_d       = rem_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          work_d = grant_data;
          id_d   = grant;
          rem_d  = accept_rem;
          if (accept_rem != 5'd0) begin
            state_d = SHIFT;
          end else begin
            // Nothing to shift: present the operand unchanged next cycle.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = grant_data;
            rsp_id_d    = grant;
          end
        end
      end
      SHIFT: begin
        work_d = shift_res;
        rem_d  = rem_after;
        if (rem_after == 5'd0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = shift_res;
          rsp_id_d    = id_q;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          ptr_d       = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      work_q      <= 8'h00;
      rem_q       <= 5'd0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      work_q      <= work_d;
      rem_q       <= rem_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_id      = rsp_id_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_shift_scheduler.sv
// ---------------------------------------------------------------------------
// tb_shift_scheduler
//   Five shift_scheduler instances, one per shifter mode (index == mode),
//   each with its own stimulus signals. Inputs change on the falling edge,
//   outputs are sampled on the falling edge or #1 after it.
// ---------------------------------------------------------------------------
module tb_shift_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- per-instance signals ----------------
  logic       r0v [5];
  logic       r0r [5];
  logic [7:0] r0d [5];
  logic [4:0] r0a [5];
  logic       r1v [5];
  logic       r1r [5];
  logic [7:0] r1d [5];
  logic [4:0] r1a [5];
  logic       rv  [5];
  logic       rspr[5];
  logic [7:0] rd  [5];
  logic       rid [5];
  logic       bsy [5];
  logic [1:0] dst [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    shift_scheduler #(.SHIFTER_MODE(g)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (r0v[g]),
      .req0_ready (r0r[g]),
      .req0_data  (r0d[g]),
      .req0_amount(r0a[g]),
      .req1_valid (r1v[g]),
      .req1_ready (r1r[g]),
      .req1_data  (r1d[g]),
      .req1_amount(r1a[g]),
      .rsp_valid  (rv[g]),
      .rsp_ready  (rspr[g]),
      .rsp_data   (rd[g]),
      .rsp_id     (rid[g]),
      .busy       (bsy[g]),
      .dbg_state_o(dst[g])
    );
  end

  // ---------------- scoreboard ----------------
  int         total = 0;
  int         bad   = 0;
  logic [8:0] exp_q[$];   // {id, data} of the op in flight
  bit         ptr_m[5];   // reference round-robin pointer per instance

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] model_shift(input int mode, input logic [7:0] d,
                                             input logic [4:0] a);
    logic [39:0]        u;
    logic signed [39:0] s;
    logic [15:0]        dd;
    int                 r;
    r  = int'(a) % 8;
    dd = {d, d};
    u  = {32'd0, d};
    s  = $signed({{32{d[7]}}, d});
    case (mode)
      0: begin u = u << a; return u[7:0]; end
      1: begin dd = dd << r; return dd[15:8]; end
      2: begin u = u >> a; return u[7:0]; end
      3: begin s = s >>> a; return s[7:0]; end
      default: begin dd = dd >> r; return dd[7:0]; end
    endcase
  endfunction

  // Cycle index (accept = 0) in which the response first shows.
  function automatic int model_lat(input int mode, input logic [4:0] a);
    int rem;
    rem = (mode == 1 || mode == 4) ? int'(a) % 8 : int'(a);
    return (rem + 6) / 7 + 1;
  endfunction

  function automatic bit model_grant(input int m, input bit v0, input bit v1);
    return (v0 && v1) ? ptr_m[m] : v1;
  endfunction

  // ---------------- driver ----------------
  // Called on a falling edge; returns on a falling edge with the DUT idle.
  // Valids stay high for the whole op (readies must stay low), operands are
  // scrambled after acceptance, and the response is held off for `hold`
  // cycles.
  task automatic do_op(input int m, input bit v0, input bit v1,
                       input logic [7:0] d0, input logic [4:0] a0,
                       input logic [7:0] d1, input logic [4:0] a1,
                       input logic [7:0] ed, input int el, input int hold,
                       input string nm);
    bit         g;
    int         k;
    bit         rdy_bad;
    bit         unstable;
    logic [7:0] hd;
    logic       hid;
    logic [8:0] e;
    g = model_grant(m, v0, v1);
    rspr[m] = (hold == 0);
    r0v[m] = v0; r0d[m] = d0; r0a[m] = a0;
    r1v[m] = v1; r1d[m] = d1; r1a[m] = a1;
    #1;
    chk({nm, "_ready0"}, int'(r0r[m]), int'(!g));
    chk({nm, "_ready1"}, int'(r1r[m]), int'(g));
    @(posedge clk);
    exp_q.push_back({g, ed});
    #1;
    r0d[m] = 8'($urandom); r0a[m] = 5'($urandom);
    r1d[m] = 8'($urandom); r1a[m] = 5'($urandom);
    k = 1;
    rdy_bad = 0;
    @(negedge clk);
    while (!rv[m] && k < 20) begin
      if (r0r[m] || r1r[m] || !bsy[m]) rdy_bad = 1;
      @(negedge clk);
      k++;
    end
    chk({nm, "_latency"}, k, el);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
    chk({nm, "_data"}, int'(rd[m]), int'(e[7:0]));
    chk({nm, "_id"}, int'(rid[m]), int'(e[8]));
    chk({nm, "_busy"}, int'(bsy[m]), 1);
    hd = rd[m];
    hid = rid[m];
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rv[m] || rd[m] !== hd || rid[m] !== hid) unstable = 1;
      if (r0r[m] || r1r[m]) rdy_bad = 1;
    end
    if (hold > 0) chk({nm, "_held_stable"}, int'(unstable), 0);
    chk({nm, "_no_ready_in_flight"}, int'(rdy_bad), 0);
    r0v[m] = 0;
    r1v[m] = 0;
    rspr[m] = 1;
    @(posedge clk);
    #1;
    chk({nm, "_rsp_dropped"}, int'(rv[m]), 0);
    ptr_m[m] = !g;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 0;
    #2;
    rst_n = 1;
    for (int i = 0; i < 5; i++) ptr_m[i] = 0;
    @(negedge clk);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int         mode;
    bit         id;
    logic [7:0] data;
    logic [4:0] amt;
    logic [7:0] exp_data;
    int         exp_lat;
  } vec_t;

  vec_t vecs[13];

  // ---------------- main ----------------
  initial begin
    vecs[0]  = '{0, 1'b0, 8'h81, 5'd1,  8'h02, 2};
    vecs[1]  = '{0, 1'b1, 8'h01, 5'd31, 8'h00, 6};
    vecs[2]  = '{0, 1'b0, 8'h5A, 5'd0,  8'h5A, 1};
    vecs[3]  = '{3, 1'b0, 8'h80, 5'd20, 8'hFF, 4};
    vecs[4]  = '{3, 1'b1, 8'h40, 5'd6,  8'h01, 2};
    vecs[5]  = '{4, 1'b0, 8'h01, 5'd9,  8'h80, 2};
    vecs[6]  = '{1, 1'b1, 8'h81, 5'd8,  8'h81, 1};
    vecs[7]  = '{2, 1'b0, 8'hF0, 5'd12, 8'h00, 3};
    vecs[8]  = '{2, 1'b1, 8'hB4, 5'd3,  8'h16, 2};
    vecs[9]  = '{3, 1'b0, 8'h7F, 5'd31, 8'h00, 6};
    vecs[10] = '{0, 1'b1, 8'h03, 5'd7,  8'h80, 2};
    vecs[11] = '{1, 1'b0, 8'h81, 5'd1,  8'h03, 2};
    vecs[12] = '{4, 1'b1, 8'h96, 5'd31, 8'h2D, 2};

    for (int i = 0; i < 5; i++) begin
      r0v[i] = 0; r0d[i] = 0; r0a[i] = 0;
      r1v[i] = 0; r1d[i] = 0; r1a[i] = 0;
      rspr[i] = 1; ptr_m[i] = 0;
    end

    // Reset values; a valid held during reset must not see ready.
    r0v[0] = 1;
    r1v[2] = 1;
    repeat (2) @(negedge clk);
    chk("reset_ready0", int'(r0r[0]), 0);
    chk("reset_ready1", int'(r1r[2]), 0);
    for (int i = 0; i < 5; i++) begin
      chk("reset_rsp_valid", int'(rv[i]), 0);
      chk("reset_rsp_data", int'(rd[i]), 0);
      chk("reset_busy", int'(bsy[i]), 0);
    end
    r0v[0] = 0;
    r1v[2] = 0;
    rst_n = 1;
    @(negedge clk);

    // Table-driven single-requester ops.
    foreach (vecs[i]) begin
      if (vecs[i].id)
        do_op(vecs[i].mode, 0, 1, 8'h00, 5'd0, vecs[i].data, vecs[i].amt,
              vecs[i].exp_data, vecs[i].exp_lat, 0, $sformatf("vec%0d", i));
      else
        do_op(vecs[i].mode, 1, 0, vecs[i].data, vecs[i].amt, 8'h00, 5'd0,
              vecs[i].exp_data, vecs[i].exp_lat, 0, $sformatf("vec%0d", i));
    end

    // Both valid after reset: order 0,1,0,1.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      chk("arb_ptr_order", int'(model_grant(0, 1, 1)), i % 2);
      do_op(0, 1, 1, 8'h11, 5'd2, 8'h22, 5'd3, (i % 2) ? 8'h10 : 8'h44, 2, 0,
            $sformatf("arb%0d", i));
    end
    // Lone req1 wins with the pointer at 0.
    do_op(0, 0, 1, 8'h00, 5'd0, 8'h0F, 5'd4, 8'hF0, 2, 0, "lone_req1");

    // Backpressure: response held 5 cycles.
    do_op(0, 1, 1, 8'h03, 5'd9, 8'hC3, 5'd1, model_grant(0, 1, 1) ? 8'h86 : 8'h00,
          model_grant(0, 1, 1) ? 2 : 3, 5, "backpressure");

    // Reset in the middle of an amount-31 op.
    do_op(0, 1, 0, 8'h01, 5'd3, 8'h00, 5'd0, 8'h08, 2, 0, "pre_reset");
    r0v[0] = 1; r0d[0] = 8'h01; r0a[0] = 5'd31;
    @(posedge clk);
    repeat (2) @(negedge clk);
    #2;
    chk("mid_busy_before_reset", int'(bsy[0]), 1);
    rst_n = 0;
    #1;
    chk("mid_reset_rsp_valid", int'(rv[0]), 0);
    chk("mid_reset_rsp_data", int'(rd[0]), 0);
    chk("mid_reset_rsp_id", int'(rid[0]), 0);
    chk("mid_reset_busy", int'(bsy[0]), 0);
    chk("mid_reset_ready0", int'(r0r[0]), 0);
    r0v[0] = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) ptr_m[i] = 0;
    begin
      bit seen;
      seen = 0;
      repeat (10) begin
        @(negedge clk);
        if (rv[0]) seen = 1;
      end
      chk("no_rsp_after_reset", int'(seen), 0);
    end
    // Pointer must be back at requester 0.
    do_op(0, 1, 1, 8'h01, 5'd1, 8'h01, 5'd2, 8'h02, 2, 0, "ptr_after_reset");

    // Randomized ops against the reference model.
    for (int n = 0; n < 80; n++) begin
      int         m;
      int         pat;
      bit         v0, v1, g;
      logic [7:0] d0, d1;
      logic [4:0] a0, a1;
      m   = int'($urandom_range(0, 4));
      pat = int'($urandom_range(1, 3));
      v0  = pat[0];
      v1  = pat[1];
      d0  = 8'($urandom);
      d1  = 8'($urandom);
      a0  = 5'($urandom);
      a1  = 5'($urandom);
      g   = model_grant(m, v0, v1);
      do_op(m, v0, v1, d0, a0, d1, a1,
            g ? model_shift(m, d1, a1) : model_shift(m, d0, a0),
            g ? model_lat(m, a1) : model_lat(m, a0),
            int'($urandom_range(0, 2)), $sformatf("rand%0d_m%0d", n, m));
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
